// File: rtl/fmps_pkg.sv
// rtl/fmps_pkg.sv - shared constants and state type for the FMPS write link
package fmps_pkg;

  localparam logic [15:0] FMPS_MAGIC   = 16'hB6CF;
  localparam int          HDR_EN_BIT   = 15;
  localparam int          HDR_IDX_OFS  = 10;
  localparam int          INVALID_FMPS = 31;
  localparam int          INVALID_CC   = 30;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } fmps_state_e;

endpackage

// File: rtl/fmps_write_link.sv
// rtl/fmps_write_link.sv - emits a two-beat header/data FMPS packet per FAstrobe
module fmps_write_link
  import fmps_pkg::*;
#(
  parameter int    INDEX_WIDTH = 5,
  parameter string dbg         = "false"
) (
  input  logic                   auroraClk,
  input  logic                   auroraRst_n,
  input  logic                   FAstrobe,
  input  logic                   fmpsEnabled,
  input  logic [INDEX_WIDTH-1:0] fmpsIndex,
  input  logic                   dataStrobe,
  input  logic [29:0]            dataIn,
  input  logic                   markBad,
  output logic                   TVALID,
  input  logic                   TREADY,
  output logic                   TLAST,
  output logic [31:0]            TDATA,
  output logic                   busy,
  output logic [15:0]            sentCounter,
  output logic [7:0]             overrunCount
);

  (* mark_debug = dbg *) fmps_state_e state_q;
  fmps_state_e state_d;

  (* mark_debug = dbg *) logic tvalid_q;

  logic [29:0]            hold_q;
  logic                   fresh_q;

  logic                   en_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic                   bad_q;
  logic                   stale_q;
  logic [29:0]            payload_q;

  (* mark_debug = dbg *) logic [15:0] sent_q;
  (* mark_debug = dbg *) logic [7:0]  overrun_q;

  logic accept;
  logic drop;
  logic data_done;
  logic [31:0] hdr_word;
  logic [31:0] data_word;

  // A request is only taken from IDLE; anything arriving while a packet is
  // in flight (including its last handshake cycle) counts as an overrun.
  assign accept    = FAstrobe && (state_q == ST_IDLE);
  assign drop      = FAstrobe && (state_q != ST_IDLE);
  assign data_done = (state_q == ST_DATA) && TREADY;

  // Next-state logic for the header/data sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (FAstrobe) state_d = ST_HEADER;
      ST_HEADER: if (TREADY)   state_d = ST_DATA;
      ST_DATA:   if (TREADY)   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register and registered TVALID, which tracks the next state.
  always_ff @(posedge auroraClk or negedge auroraRst_n) begin
    if (!auroraRst_n) begin
      state_q  <= ST_IDLE;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= (state_d != ST_IDLE);
    end
  end

  // Holding register for the latest payload and its freshness flag; a same
  // cycle dataStrobe bypasses into the snapshot so fresh ends cleared.
  always_ff @(posedge auroraClk or negedge auroraRst_n) begin
    if (!auroraRst_n) begin
      hold_q  <= '0;
      fresh_q <= 1'b0;
    end else begin
      if (dataStrobe) hold_q <= dataIn;
      if (accept)          fresh_q <= 1'b0;
      else if (dataStrobe) fresh_q <= 1'b1;
    end
  end

  // Packet fields are captured once in the accepting cycle and held for both beats.
  always_ff @(posedge auroraClk or negedge auroraRst_n) begin
    if (!auroraRst_n) begin
      en_q      <= 1'b0;
      idx_q     <= '0;
      bad_q     <= 1'b0;
      stale_q   <= 1'b0;
      payload_q <= '0;
    end else if (accept) begin
      en_q      <= fmpsEnabled;
      idx_q     <= fmpsIndex;
      bad_q     <= markBad;
      stale_q   <= dataStrobe ? 1'b0 : !fresh_q;
      payload_q <= dataStrobe ? dataIn : hold_q;
    end
  end

  // Completed-packet counter (wrapping) and dropped-request counter (saturating).
  always_ff @(posedge auroraClk or negedge auroraRst_n) begin
    if (!auroraRst_n) begin
      sent_q    <= '0;
      overrun_q <= '0;
    end else begin
      if (data_done) sent_q <= sent_q + 16'd1;
      if (drop && (overrun_q != 8'hFF)) overrun_q <= overrun_q + 8'd1;
    end
  end

  // Assemble both beat words from the snapshot registers.
  always_comb begin
    hdr_word                              = '0;
    hdr_word[31:16]                       = FMPS_MAGIC;
    hdr_word[HDR_EN_BIT]                  = en_q;
    hdr_word[HDR_IDX_OFS +: INDEX_WIDTH]  = idx_q;
    data_word                             = '0;
    data_word[INVALID_FMPS]               = stale_q;
    data_word[INVALID_CC]                 = bad_q;
    data_word[29:0]                       = payload_q;
  end

  // Output word is a pure function of registers, so it cannot move under backpressure.
  always_comb begin
    TDATA = '0;
    case (state_q)
      ST_HEADER: TDATA = hdr_word;
      ST_DATA:   TDATA = data_word;
      default:   TDATA = '0;
    endcase
  end

  if (dbg == "true") begin : g_debug_marked
  end

  assign TVALID       = tvalid_q;
  assign TLAST        = (state_q == ST_DATA);
  assign busy         = (state_q != ST_IDLE);
  assign sentCounter  = sent_q;
  assign overrunCount = overrun_q;

endmodule

// File: doc/fmps_write_link.md
FMPS_WRITE_LINK -- requirements
Module: fmps_write_link

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameter INDEX_WIDTH, default 5, cell/FMPS index width; legal range 1..5.
REQ-003 Parameter dbg, default "false", mark_debug attribute value.
REQ-004 auroraClk  input  1  sole clock; all logic rising-edge.
REQ-005 auroraRst_n  input  1  asynchronous active-low reset.
REQ-006 FAstrobe  input  1  one-cycle request to emit one packet.
REQ-007 fmpsEnabled  input  1  copied into header bit 15.
REQ-008 fmpsIndex  input  INDEX_WIDTH  own index, copied into header bits [10+:INDEX_WIDTH].
REQ-009 dataStrobe  input  1  one-cycle qualifier for dataIn.
REQ-010 dataIn  input  30  FMPS payload.
REQ-011 markBad  input  1  when high at snapshot, sets data-word bit 30.
REQ-012 TVALID  output  1  AXI-stream valid.
REQ-013 TREADY  input  1  AXI-stream ready.
REQ-014 TLAST  output  1  high on the data beat only.
REQ-015 TDATA  output  32  stream word.
REQ-016 busy  output  1  high while state is not IDLE.
REQ-017 sentCounter  output  16  completed packets, wraps 0xFFFF->0.
REQ-018 overrunCount  output  8  dropped strobes, saturates at 0xFF.

Function
REQ-019 The block SHALL use states IDLE, HEADER and DATA.
REQ-020 Transitions: IDLE->HEADER on FAstrobe; HEADER->DATA on TVALID&TREADY; DATA->IDLE on TVALID&TREADY.
REQ-021 TVALID SHALL be high exactly in HEADER and DATA, and SHALL be registered.
REQ-022 Latency: FAstrobe in cycle N produces header TVALID in cycle N+1.
REQ-023 Header word: [31:16]=16'hB6CF; [15]=fmpsEnabled; [10+:INDEX_WIDTH]=fmpsIndex; all other bits 0.
REQ-024 Data word: [31]=stale; [30]=markBad; [29:0]=payload.
REQ-025 fmpsEnabled, fmpsIndex, markBad and payload SHALL be snapshotted in the FAstrobe cycle and held through both beats.
REQ-026 TDATA and TLAST SHALL stay stable while TVALID=1 and TREADY=0; TREADY is ignored outside HEADER and DATA.
REQ-027 On dataStrobe, dataIn SHALL be latched into a holding register and a fresh flag set.
REQ-028 At snapshot, stale = !fresh; the fresh flag clears; payload = holding register (the last value, even if stale).
REQ-029 On simultaneous dataStrobe and accepted FAstrobe, the new dataIn SHALL be the payload with stale=0, and fresh SHALL end cleared.
REQ-030 An FAstrobe while busy, including the cycle of the final DATA handshake, SHALL be dropped: no snapshot, overrunCount+1 (saturating), packet in flight unaffected.
REQ-031 sentCounter SHALL increment on the DATA-beat handshake.
REQ-032 TLAST=1 only when state is DATA.

Reset
REQ-033 Asserting auroraRst_n low SHALL immediately give: state IDLE, TVALID=0, TLAST=0, TDATA=0, busy=0, sentCounter=0, overrunCount=0, fresh=0, holding register=0.
REQ-034 Reset mid-packet SHALL abort the packet without completing the beat; the first packet after release starts with a header.
REQ-035 Deassertion is synchronised by the instantiating wrapper; the block requires no synchroniser of its own.

Structure
REQ-036 Shared package fmps_pkg SHALL hold:
- magic 16'hB6CF;
- header enable bit 15 and index offset 10;
- data bits INVALID_FMPS=31 and INVALID_CC=30;
- the state enum.
REQ-037 No sub-module; single flat module of roughly 150-250 lines.

Verification
REQ-038 Bench scenarios:
- Basic: dataStrobe with 30'h1234567, then FAstrobe, index 3, enabled=1, TREADY=1 -> TDATA 32'hB6CF8C00, then 32'h01234567 with TLAST; sentCounter=1.
- Backpressure: TREADY=0 for 5 cycles on the header -> header held stable; DATA follows only after the handshake.
- Stale: two FAstrobes with no dataStrobe between them -> second data word has bit31=1 and the same payload.
- Overrun: FAstrobe while busy, then 300 more while busy -> overrunCount saturates at 0xFF, no extra packets.
- markBad=1 and simultaneous dataStrobe/FAstrobe -> data bit30=1, bit31=0, new payload sent.
- Reset asserted during the DATA beat -> outputs zero immediately; next FAstrobe yields a header.
